mjpg_stream_parser: RTL and testbench

- Consumes the JPEG byte stream produced by the MJPEG encoder's output FIFO, one byte per dequeue.
- Tracks markers and skips header segments.
- Captures frame width and height from the SOF0 segment.
- Removes 0xFF00 byte stuffing and emits the unstuffed entropy-coded bytes to a downstream consumer (bit reader / checker) over a valid/ready handshake, with frame boundary pulses and a per-frame byte count.

---
 rtl/mjpg_stream_parser_if.sv | 20 ++
 rtl/mjpg_stream_parser.sv | 241 ++++++++++++++++++++++++
 tb/tb_mjpg_stream_parser.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mjpg_stream_parser_if.sv
// Byte-stream handshake bundle for the MJPEG stream parser: the source FIFO side
// (show-ahead with a dequeue strobe) and the unstuffed entropy-byte side (valid/ready).
interface mjpg_stream_parser_if;
    logic       src_ready;
    logic [7:0] src_data;
    logic       src_dequeue;
    logic       ecs_valid;
    logic [7:0] ecs_data;
    logic       ecs_ready;

    modport master (
        input  src_ready, src_data, ecs_ready,
        output src_dequeue, ecs_valid, ecs_data
    );

    modport slave (
        output src_ready, src_data, ecs_ready,
        input  src_dequeue, ecs_valid, ecs_data
    );
endinterface

// File: rtl/mjpg_stream_parser.sv
// JPEG byte-stream parser: tracks markers, skips header segments, captures SOF0 dimensions and
// emits the unstuffed entropy-coded bytes with frame boundary pulses and a per-frame byte count.
module mjpg_stream_parser #(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned DIM_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mjpg_stream_parser_if.master bus,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic [DIM_W-1:0]     width,
    output logic [DIM_W-1:0]     height,
    output logic                 dim_valid,
    output logic [CNT_W-1:0]     frame_bytes,
    output logic                 err
);

    typedef enum logic [2:0] {
        StIdle, StMark, StLenHi, StLenLo, StSeg, StEcs, StEcsFf
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       marker_q, marker_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [15:0]      remain_q, remain_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      hgt_tmp_q, hgt_tmp_d;
    logic [7:0]       wid_hi_q, wid_hi_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic             dim_valid_q, dim_valid_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] frame_bytes_q, frame_bytes_d;
    logic             in_frame_q, in_frame_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             err_q, err_d;
    logic             ecs_valid_q, ecs_valid_d;
    logic [7:0]       ecs_data_q, ecs_data_d;

    logic             deq;
    logic [7:0]       b;
    logic [15:0]      len;
    logic             do_soi, do_eoi, emit;
    logic [7:0]       emit_byte;

    assign deq             = bus.src_ready & (~ecs_valid_q | bus.ecs_ready);
    assign bus.src_dequeue = deq;
    assign b               = bus.src_data;
    assign len             = {len_hi_q, b};

    always_comb begin
        state_d       = state_q;
        marker_d      = marker_q;
        len_hi_d      = len_hi_q;
        remain_d      = remain_q;
        idx_d         = idx_q;
        hgt_tmp_d     = hgt_tmp_q;
        wid_hi_d      = wid_hi_q;
        width_d       = width_q;
        height_d      = height_q;
        dim_valid_d   = dim_valid_q;
        run_d         = run_q;
        frame_bytes_d = frame_bytes_q;
        in_frame_d    = in_frame_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        err_d         = 1'b0;
        ecs_valid_d   = ecs_valid_q;
        ecs_data_d    = ecs_data_q;
        do_soi        = 1'b0;
        do_eoi        = 1'b0;
        emit          = 1'b0;
        emit_byte     = b;

        if (deq) begin
            unique case (state_q)
                StIdle: begin
                    if (b == 8'hFF) state_d = StMark;
                end
                StMark: begin
                    if (b == 8'hFF) begin
                        state_d = StMark;
                    end else if (b == 8'hD8) begin
                        do_soi = 1'b1;
                        err_d  = in_frame_q;
                    end else if (b == 8'hD9) begin
                        do_eoi = 1'b1;
                    end else if (b[7:3] == 5'b11010 || b == 8'h01) begin
                        state_d = StIdle;
                    end else if (b == 8'h00) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        marker_d = b;
                        state_d  = StLenHi;
                    end
                end
                StLenHi: begin
                    len_hi_d = b;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    idx_d = 3'd0;
                    if (len < 16'd2) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // A short SOF0 can never reach the width bytes, so only the error is needed
                        if (marker_q == 8'hC0 && len < 16'd7) err_d = 1'b1;
                        if (len == 16'd2) begin
                            state_d = (marker_q == 8'hDA) ? StEcs : StIdle;
                        end else begin
                            remain_d = len - 16'd2;
                            state_d  = StSeg;
                        end
                    end
                end
                StSeg: begin
                    remain_d = remain_q - 16'd1;
                    if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
                    if (marker_q == 8'hC0) begin
                        if (idx_q == 3'd1) hgt_tmp_d[15:8] = b;
                        if (idx_q == 3'd2) hgt_tmp_d[7:0] = b;
                        if (idx_q == 3'd3) wid_hi_d = b;
                        if (idx_q == 3'd4) begin
                            width_d     = DIM_W'({wid_hi_q, b});
                            height_d    = DIM_W'(hgt_tmp_q);
                            dim_valid_d = 1'b1;
                        end
                    end
                    if (remain_q == 16'd1) state_d = (marker_q == 8'hDA) ? StEcs : StIdle;
                end
                StEcs: begin
                    if (b == 8'hFF) state_d = StEcsFf;
                    else emit = 1'b1;
                end
                StEcsFf: begin
                    if (b == 8'h00) begin
                        emit      = 1'b1;
                        emit_byte = 8'hFF;
                        state_d   = StEcs;
                    end else if (b[7:3] == 5'b11010) begin
                        state_d = StEcs;
                    end else if (b == 8'hFF) begin
                        state_d = StEcsFf;
                    end else if (b == 8'hD9) begin
                        do_eoi = 1'b1;
                    end else if (b == 8'hD8) begin
                        do_soi = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        marker_d = b;
                        state_d  = StLenHi;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (do_soi) begin
            frame_start_d = 1'b1;
            dim_valid_d   = 1'b0;
            run_d         = '0;
            in_frame_d    = 1'b1;
            state_d       = StIdle;
        end
        if (do_eoi) begin
            state_d = StIdle;
            if (in_frame_q) begin
                frame_end_d   = 1'b1;
                frame_bytes_d = run_q;
                in_frame_d    = 1'b0;
            end
        end

        // Reload in the same edge as a downstream accept so a streaming run has no bubble
        if (emit) begin
            if (run_q != {CNT_W{1'b1}}) run_d = run_q + CNT_W'(1);
            ecs_valid_d = 1'b1;
            ecs_data_d  = emit_byte;
        end else if (bus.ecs_ready) begin
            ecs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            marker_q      <= '0;
            len_hi_q      <= '0;
            remain_q      <= '0;
            idx_q         <= '0;
            hgt_tmp_q     <= '0;
            wid_hi_q      <= '0;
            width_q       <= '0;
            height_q      <= '0;
            dim_valid_q   <= 1'b0;
            run_q         <= '0;
            frame_bytes_q <= '0;
            in_frame_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_q         <= 1'b0;
            ecs_valid_q   <= 1'b0;
            ecs_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            marker_q      <= marker_d;
            len_hi_q      <= len_hi_d;
            remain_q      <= remain_d;
            idx_q         <= idx_d;
            hgt_tmp_q     <= hgt_tmp_d;
            wid_hi_q      <= wid_hi_d;
            width_q       <= width_d;
            height_q      <= height_d;
            dim_valid_q   <= dim_valid_d;
            run_q         <= run_d;
            frame_bytes_q <= frame_bytes_d;
            in_frame_q    <= in_frame_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            err_q         <= err_d;
            ecs_valid_q   <= ecs_valid_d;
            ecs_data_q    <= ecs_data_d;
        end
    end

    assign bus.ecs_valid = ecs_valid_q;
    assign bus.ecs_data  = ecs_data_q;
    assign frame_start   = frame_start_q;
    assign frame_end     = frame_end_q;
    assign width         = width_q;
    assign height        = height_q;
    assign dim_valid     = dim_valid_q;
    assign frame_bytes   = frame_bytes_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Directed bench for mjpg_stream_parser: full frames, backpressure and source gaps,
// stuffing/restart handling, bad lengths, SOI inside entropy data and mid-frame reset.
module tb_mjpg_stream_parser;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned DIM_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start, frame_end, dim_valid, err;
    logic [DIM_W-1:0] width, height;
    logic [CNT_W-1:0] frame_bytes;

    always #5 clk = ~clk;

    mjpg_stream_parser_if bus ();

    mjpg_stream_parser #(
        .CNT_W(CNT_W),
        .DIM_W(DIM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .width      (width),
        .height     (height),
        .dim_valid  (dim_valid),
        .frame_bytes(frame_bytes),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit gap_mode = 1'b0;

    // Monitor-owned tallies; the stimulus only reads them and compares deltas
    logic [7:0] got_q[$];
    int fs_cnt = 0, fe_cnt = 0, err_cnt = 0, both_cnt = 0, bp_viol = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.ecs_valid && bus.ecs_ready) got_q.push_back(bus.ecs_data);
            if (frame_start) fs_cnt <= fs_cnt + 1;
            if (frame_end) fe_cnt <= fe_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (err && frame_start) both_cnt <= both_cnt + 1;
            if (bus.src_dequeue && bus.ecs_valid && !bus.ecs_ready) bp_viol <= bp_viol + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready();
        case (ready_mode)
            0:       bus.ecs_ready = 1'b1;
            1:       bus.ecs_ready = (cyc % 3 == 0);
            default: bus.ecs_ready = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        set_ready();
    endtask

    task automatic push(input logic [7:0] b);
        int guard;
        bit done;
        guard = 0;
        done = 1'b0;
        bus.src_data = b;
        while (!done) begin
            bus.src_ready = !(gap_mode && (cyc % 4 == 1));
            #1;
            done = bus.src_dequeue;
            tick();
            guard++;
            if (!done && guard > 40) begin
                tests++;
                fails++;
                $error("FAIL push_timeout: byte %0h not dequeued, observed 0 expected 1", b);
                done = 1'b1;
            end
        end
        bus.src_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] s[$]);
        foreach (s[i]) push(s[i]);
    endtask

    task automatic drain();
        ready_mode = 0;
        bus.ecs_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic check_seq(input string tag, input int base, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got_q.size() - base), 32'(exp.size()));
        foreach (exp[i]) begin
            if (base + i < got_q.size()) check(tag, 32'(got_q[base + i]), 32'(exp[i]));
        end
    endtask

    logic [7:0] frame1[$];
    logic [7:0] s[$];
    logic [7:0] e[$];
    int q0, fs0, fe0, er0, bo0, bp0;

    task automatic snap();
        q0  = got_q.size();
        fs0 = fs_cnt;
        fe0 = fe_cnt;
        er0 = err_cnt;
        bo0 = both_cnt;
        bp0 = bp_viol;
    endtask

    initial begin
        frame1 = '{8'hFF, 8'hD9, 8'hFF, 8'hD8,
                   8'hFF, 8'hE0, 8'h00, 8'h10, 8'h4A, 8'h46, 8'h49, 8'h46, 8'h00, 8'h01,
                   8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00,
                   8'hFF, 8'hDB, 8'h00, 8'h05, 8'h00, 8'h10, 8'h0B,
                   8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h02, 8'hD0, 8'h05, 8'h00, 8'h03,
                   8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01,
                   8'hFF, 8'hC4, 8'h00, 8'h04, 8'hAA, 8'hBB,
                   8'hFF, 8'hDA, 8'h00, 8'h0C, 8'h03, 8'h01, 8'h00, 8'h02, 8'h11, 8'h03,
                   8'h11, 8'h00, 8'h3F, 8'h00,
                   8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'hFF, 8'hD9};

        rst = 1'b1;
        bus.src_ready = 1'b0;
        bus.src_data = 8'h00;
        bus.ecs_ready = 1'b1;
        repeat (3) tick();
        check("rst_ecs_valid", 32'(bus.ecs_valid), 32'd0);
        check("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        check("rst_dim_valid", 32'(dim_valid), 32'd0);
        check("rst_width", 32'(width), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Baseline frame
        snap();
        send(frame1);
        drain();
        e = '{8'h12, 8'h34, 8'hFF, 8'h56};
        check_seq("t1_ecs", q0, e);
        check("t1_frame_start", 32'(fs_cnt - fs0), 32'd1);
        check("t1_frame_end", 32'(fe_cnt - fe0), 32'd1);
        check("t1_err", 32'(err_cnt - er0), 32'd0);
        check("t1_width", 32'(width), 32'd1280);
        check("t1_height", 32'(height), 32'd720);
        check("t1_dim_valid", 32'(dim_valid), 32'd1);
        check("t1_frame_bytes", 32'(frame_bytes), 32'd4);

        // Backpressure 1-of-3 plus source gaps
        snap();
        ready_mode = 1;
        gap_mode = 1'b1;
        send(frame1);
        gap_mode = 1'b0;
        drain();
        check_seq("t2_ecs", q0, e);
        check("t2_bp_violation", 32'(bp_viol - bp0), 32'd0);
        check("t2_frame_start", 32'(fs_cnt - fs0), 32'd1);
        check("t2_frame_end", 32'(fe_cnt - fe0), 32'd1);
        check("t2_err", 32'(err_cnt - er0), 32'd0);
        check("t2_frame_bytes", 32'(frame_bytes), 32'd4);

        // Fill bytes before stuffing, restart marker dropped
        snap();
        s = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
              8'h06, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hBB, 8'hFF, 8'hD3, 8'hCC, 8'hDD,
              8'hFF, 8'hD9};
        send(s);
        drain();
        e = '{8'hAA, 8'hFF, 8'hBB, 8'hCC, 8'hDD};
        check_seq("t3_ecs", q0, e);
        check("t3_frame_bytes", 32'(frame_bytes), 32'd5);
        check("t3_dim_valid", 32'(dim_valid), 32'd0);
        check("t3_err", 32'(err_cnt - er0), 32'd0);

        // Bad length outside a frame, junk, then resync on SOI
        snap();
        s = '{8'hFF, 8'hE1, 8'h00, 8'h01, 8'h11, 8'h22, 8'hFF, 8'hD8};
        send(s);
        drain();
        check("t4_err", 32'(err_cnt - er0), 32'd1);
        check("t4_frame_start", 32'(fs_cnt - fs0), 32'd1);
        check("t4_err_with_start", 32'(both_cnt - bo0), 32'd0);

        // SOI inside entropy data restarts the frame and its byte count
        snap();
        s = '{8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h01, 8'h02, 8'h03, 8'hFF, 8'hD8,
              8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'hFF, 8'hD9};
        send(s);
        drain();
        e = '{8'h01, 8'h02, 8'h03, 8'h07};
        check_seq("t5_ecs", q0, e);
        check("t5_err_with_start", 32'(both_cnt - bo0), 32'd1);
        check("t5_err", 32'(err_cnt - er0), 32'd1);
        check("t5_frame_end", 32'(fe_cnt - fe0), 32'd1);
        check("t5_frame_bytes", 32'(frame_bytes), 32'd1);

        // Reset while a byte is held under backpressure
        s = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
              8'h06};
        send(s);
        ready_mode = 2;
        bus.ecs_ready = 1'b0;
        push(8'h55);
        check("t6_held_valid", 32'(bus.ecs_valid), 32'd1);
        check("t6_held_data", 32'(bus.ecs_data), 32'h55);
        rst = 1'b1;
        tick();
        check("t6_rst_ecs_valid", 32'(bus.ecs_valid), 32'd0);
        check("t6_rst_width", 32'(width), 32'd0);
        check("t6_rst_height", 32'(height), 32'd0);
        check("t6_rst_frame_bytes", 32'(frame_bytes), 32'd0);
        check("t6_rst_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        ready_mode = 0;
        tick();
        snap();
        send(frame1);
        drain();
        e = '{8'h12, 8'h34, 8'hFF, 8'h56};
        check_seq("t6_ecs", q0, e);
        check("t6_width", 32'(width), 32'd1280);
        check("t6_height", 32'(height), 32'd720);
        check("t6_frame_bytes", 32'(frame_bytes), 32'd4);
        check("t6_err", 32'(err_cnt - er0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
